// File: rtl/dmem_bank_if.sv
// Load/store port of the dmem_bank data memory.
// The datapath side uses the master modport, the memory uses the slave modport.
interface dmem_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic                  init_req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     a;
  logic [DATA_W-1:0]     d;
  logic [DATA_W-1:0]     q;
  logic                  busy;
  logic                  wr_drop;

  modport master (
    output init_req, we, be, a, d,
    input  q, busy, wr_drop
  );

  modport slave (
    input  init_req, we, be, a, d,
    output q, busy, wr_drop
  );
endinterface

// File: rtl/dmem_bank.sv
// dmem_bank: parametrised single-port data memory with per-byte write enables
// and a sequential clear engine that sweeps FILL into every word after reset
// or on init_req.
// Optional feature: define DMEM_RDATA_REG_EN for a registered read port
// (one-cycle read latency, q resets to 0). Undefined: combinational q.
module dmem_bank #(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 6,
  parameter int          DEPTH  = 64,
  parameter logic [31:0] FILL   = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_bank_if.slave  bus
);

  localparam int                LANES  = DATA_W / 8;
  localparam logic [DATA_W-1:0] FILL_W = DATA_W'(FILL);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_ptr;
  logic                clr_last;
  logic                in_range;
  logic                sweep_we;
  logic                wr_ok;
  logic                drop_nxt;
  logic                wr_drop_r;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   ram [DEPTH];

  // Last word of the sweep and address range decode.
  assign clr_last = (clr_ptr == ADDR_W'(DEPTH - 1));
  assign in_range = (32'(bus.a) < DEPTH);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: sweep until the last word, restart on init_req when ready.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR: if (clr_last)     state_nxt = READY;
      READY: if (bus.init_req) state_nxt = CLEAR;
      default:                 state_nxt = CLEAR;
    endcase
  end

  // Output decode: sweep write, user write qualification, discard detection.
  always_comb begin
    sweep_we = 1'b0;
    wr_ok    = 1'b0;
    drop_nxt = 1'b0;
    bus.busy = 1'b0;
    unique case (state)
      CLEAR: begin
        bus.busy = 1'b1;
        sweep_we = 1'b1;
        drop_nxt = bus.we;
      end
      READY: begin
        wr_ok    = bus.we && !bus.init_req && in_range;
        drop_nxt = bus.we && (bus.init_req || !in_range);
      end
      default: begin
        bus.busy = 1'b1;
      end
    endcase
  end

  // Sweep pointer: advances once per CLEAR cycle, rearmed on a new clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_last ? '0 : clr_ptr + ADDR_W'(1);
    end else if (bus.init_req) begin
      clr_ptr <= '0;
    end
  end

  // Discard flag: one cycle after any write that did not land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_r <= 1'b0;
    end else begin
      wr_drop_r <= drop_nxt;
    end
  end

  assign bus.wr_drop = wr_drop_r;

  // Storage array: the sweep has priority, otherwise byte-lane merge of user writes.
  // NOTE: the array has no reset; the clear sweep initialises it so it still maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      ram[clr_ptr] <= FILL_W;
    end else if (wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.be[i]) begin
          ram[bus.a][8*i +: 8] <= bus.d[8*i +: 8];
        end
      end
    end
  end

  // Read mux: FILL while sweeping, zero outside the implemented depth.
  always_comb begin
    rd_word = '0;
    if (state == CLEAR) begin
      rd_word = FILL_W;
    end else if (in_range) begin
      rd_word = ram[bus.a];
    end
  end

`ifdef DMEM_RDATA_REG_EN
  logic [DATA_W-1:0] q_r;

  // Registered read port: q reflects the address presented one cycle earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else begin
      q_r <= rd_word;
    end
  end

  assign bus.q = q_r;
`else
  assign bus.q = rd_word;
`endif

endmodule

// File: tb/tb_dmem_bank.sv
// Self-checking bench for dmem_bank: two instances (DEPTH 64 and DEPTH 48)
// share one random stimulus stream and are compared every cycle against a
// behavioural model built from remaining-sweep counters and word arrays.
module tb_dmem_bank;

  localparam logic [31:0] FILL = 32'hFFFFFFFF;

  logic        clk;
  logic        rst_n;
  logic        init_req;
  logic        we;
  logic [3:0]  be;
  logic [5:0]  a;
  logic [31:0] d;

  int checks   = 0;
  int failures = 0;

  dmem_bank_if #(.DATA_W(32), .ADDR_W(6)) bus0 ();
  dmem_bank_if #(.DATA_W(32), .ADDR_W(6)) bus1 ();

  assign bus0.init_req = init_req;
  assign bus0.we       = we;
  assign bus0.be       = be;
  assign bus0.a        = a;
  assign bus0.d        = d;
  assign bus1.init_req = init_req;
  assign bus1.we       = we;
  assign bus1.be       = be;
  assign bus1.a        = a;
  assign bus1.d        = d;

  dmem_bank #(.DATA_W(32), .ADDR_W(6), .DEPTH(64), .FILL(FILL)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  dmem_bank #(.DATA_W(32), .ADDR_W(6), .DEPTH(48), .FILL(FILL)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] mem    [2][64];
  int          left   [2];     // sweep writes still to do; busy while nonzero
  logic        m_drop [2];
  logic [31:0] m_q    [2];     // registered-read expectation

  function automatic int dep(input int k);
    return (k == 0) ? 64 : 48;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] lanes);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) mask = mask | (32'hFF << (8 * i));
    end
    return (old & ~mask) | (nw & mask);
  endfunction

  function automatic logic [31:0] exp_read(input int k);
    if (left[k] != 0)      return FILL;
    if (int'(a) < dep(k))  return mem[k][a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_q(input int k);
`ifdef DMEM_RDATA_REG_EN
    return m_q[k];
`else
    return exp_read(k);
`endif
  endfunction

  // Model update at each edge (reset acts immediately).
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        left[k]   <= dep(k);
        m_drop[k] <= 1'b0;
        m_q[k]    <= '0;
      end else begin
        m_q[k] <= exp_read(k);
        if (left[k] != 0) begin
          mem[k][dep(k) - left[k]] <= FILL;
          left[k]   <= left[k] - 1;
          m_drop[k] <= we;
        end else if (init_req) begin
          left[k]   <= dep(k);
          m_drop[k] <= we;
        end else if (we && int'(a) >= dep(k)) begin
          m_drop[k] <= 1'b1;
        end else begin
          m_drop[k] <= 1'b0;
          if (we) mem[k][a] <= merge(mem[k][a], d, be);
        end
      end
    end
  end

  // ---------------- literal pins ----------------
  logic        pin_q_en  = 1'b0;
  int          pin_q_k   = 0;
  logic [31:0] pin_q_exp = '0;
  string       pin_q_name = "";
  logic        pin_d_en  = 1'b0;
  int          pin_d_k   = 0;
  logic        pin_d_exp = 1'b0;
  logic        pin_run_en  = 1'b0;
  int          pin_run_exp = 0;

  logic        pq_en_d   = 1'b0;
  int          pq_k_d    = 0;
  logic [31:0] pq_exp_d  = '0;
  string       pq_name_d = "";

  int busy_run = 0;
  int last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: outputs settle mid-cycle, checked at the falling edge.
  always @(negedge clk) begin
    check("q0",       bus0.q,              exp_q(0));
    check("busy0",    32'(bus0.busy),      32'(left[0] != 0));
    check("wr_drop0", 32'(bus0.wr_drop),   32'(m_drop[0]));
    check("q1",       bus1.q,              exp_q(1));
    check("busy1",    32'(bus1.busy),      32'(left[1] != 0));
    check("wr_drop1", 32'(bus1.wr_drop),   32'(m_drop[1]));

`ifdef DMEM_RDATA_REG_EN
    if (pq_en_d) check(pq_name_d, (pq_k_d != 0) ? bus1.q : bus0.q, pq_exp_d);
`else
    if (pin_q_en) check(pin_q_name, (pin_q_k != 0) ? bus1.q : bus0.q, pin_q_exp);
`endif
    pq_en_d   <= pin_q_en;
    pq_k_d    <= pin_q_k;
    pq_exp_d  <= pin_q_exp;
    pq_name_d <= pin_q_name;

    if (pin_d_en)
      check("pin_wr_drop", 32'((pin_d_k != 0) ? bus1.wr_drop : bus0.wr_drop), 32'(pin_d_exp));
    if (pin_run_en)
      check("pin_busy_cycles", 32'(last_run), 32'(pin_run_exp));

    if (!rst_n) begin
      busy_run <= 0;
    end else if (bus0.busy) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      last_run <= busy_run;
      busy_run <= 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    pin_q_en   = 1'b0;
    pin_d_en   = 1'b0;
    pin_run_en = 1'b0;
  endtask

  task automatic pin_q(input int k, input logic [31:0] exp, input string name);
    pin_q_en   = 1'b1;
    pin_q_k    = k;
    pin_q_exp  = exp;
    pin_q_name = name;
  endtask

  task automatic idle_inputs();
    init_req = 1'b0;
    we       = 1'b0;
    be       = 4'h0;
    d        = '0;
  endtask

  // Wait (bounded) for the 64-word sweep to end, then pin its length.
  task automatic wait_ready();
    idle_inputs();
    for (int i = 0; i < 200 && bus0.busy; i++) tick();
    tick();
    pin_run_en  = 1'b1;
    pin_run_exp = 64;
  endtask

  initial begin
    rst_n = 1'b0;
    a     = '0;
    idle_inputs();
    repeat (3) tick();
    rst_n = 1'b1;

    // Power-up sweep, then every word reads FILL.
    wait_ready();
    for (int i = 0; i < 64; i++) begin
      a = 6'(i);
      if (i == 0 || i == 63) pin_q(0, 32'hFFFFFFFF, "pin_after_sweep");
      tick();
    end

    // Full-word write then partial-lane write to word 5.
    we = 1'b1; be = 4'b1111; a = 6'd5; d = 32'h12345678;
    tick();
    idle_inputs(); a = 6'd5;
    pin_q(0, 32'h12345678, "pin_full_write");
    tick();
    we = 1'b1; be = 4'b0010; a = 6'd5; d = 32'hAABBCCDD;
    tick();
    idle_inputs(); a = 6'd5;
    pin_q(0, 32'h1234CC78, "pin_lane_write");
    tick();

    // Clear request with a colliding write.
    init_req = 1'b1; we = 1'b1; be = 4'b1111; a = 6'd7; d = 32'h0;
    tick();
    idle_inputs();
    pin_d_en = 1'b1; pin_d_k = 0; pin_d_exp = 1'b1;
    wait_ready();
    a = 6'd7; pin_q(0, 32'hFFFFFFFF, "pin_cleared_a7");
    tick();
    a = 6'd5; pin_q(0, 32'hFFFFFFFF, "pin_cleared_a5");
    tick();

    // Reset in the 30th sweep cycle restarts the sweep.
    init_req = 1'b1;
    tick();
    idle_inputs();
    repeat (29) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wait_ready();
    tick();

    // Out-of-range write on the 48-word instance.
    we = 1'b1; be = 4'b1111; a = 6'd50; d = 32'hCAFEF00D;
    tick();
    idle_inputs(); a = 6'd50;
    pin_d_en = 1'b1; pin_d_k = 1; pin_d_exp = 1'b1;
    pin_q(1, 32'h0, "pin_oob_read");
    tick();

    // Random traffic: writes, partial lanes, clears, rare resets.
    for (int n = 0; n < 3000; n++) begin
      init_req = ($urandom_range(0, 39) == 0);
      we       = 1'($urandom_range(0, 1));
      be       = 4'($urandom);
      a        = 6'($urandom);
      d        = $urandom;
      if ($urandom_range(0, 699) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    idle_inputs();
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
